// File: rtl/cga_mic_stack_ctrl.sv
// Four-deep microprogram return-address stack with sticky overflow/underflow flags
// and a registered shift-select that mirrors the applied command for external bit slices.
module cga_mic_stack_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HOLD,
    input  logic [1:0]  CMD,
    input  logic [13:0] DIN,
    input  logic        CLR_ERR,
    output logic [13:0] TOS,
    output logic [2:0]  DEPTH,
    output logic        EMPTY,
    output logic        FULL,
    output logic        OVF,
    output logic        UNF,
    output logic [1:0]  SEL
);

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_PUSH  = 2'b01,
        OP_POP   = 2'b10,
        OP_LDTOS = 2'b11
    } op_t;

    logic [13:0] e0, e1, e2, e3;
    op_t         op;
    logic        ovf_event;
    logic        unf_event;

    assign op        = op_t'(CMD);
    assign EMPTY     = (DEPTH == 3'd0);
    assign FULL      = (DEPTH == 3'd4);
    assign TOS       = e0;
    assign ovf_event = !HOLD && (op == OP_PUSH) && FULL;
    assign unf_event = !HOLD && (op == OP_POP) && EMPTY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            e0    <= '0;
            e1    <= '0;
            e2    <= '0;
            e3    <= '0;
            DEPTH <= 3'd0;
            OVF   <= 1'b0;
            UNF   <= 1'b0;
            SEL   <= 2'b00;
        end else begin
            // A new error event wins over a simultaneous clear.
            OVF <= ovf_event | (OVF & ~CLR_ERR);
            UNF <= unf_event | (UNF & ~CLR_ERR);
            SEL <= HOLD ? 2'b00 : CMD;
            if (!HOLD) begin
                case (op)
                    OP_PUSH: begin
                        e0 <= DIN;
                        e1 <= e0;
                        e2 <= e1;
                        e3 <= e2;
                        if (!FULL) DEPTH <= DEPTH + 3'd1;
                    end
                    OP_POP: begin
                        // Bottom entry is duplicated so the stack never fills with stale zeros.
                        e0 <= e1;
                        e1 <= e2;
                        e2 <= e3;
                        if (!EMPTY) DEPTH <= DEPTH - 3'd1;
                    end
                    OP_LDTOS: begin
                        e0 <= DIN;
                        if (EMPTY) DEPTH <= 3'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cga_mic_stack_ctrl.sv
// Directed bench for cga_mic_stack_ctrl: a list-based stack model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_cga_mic_stack_ctrl;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [1:0]  cmd;
    logic [13:0] din;
    logic        clr_err;
    logic [13:0] tos;
    logic [2:0]  depth;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic [1:0]  sel;

    int checks = 0;
    int passes = 0;

    cga_mic_stack_ctrl dut (
        .CLK     (clk),
        .RST     (rst),
        .HOLD    (hold),
        .CMD     (cmd),
        .DIN     (din),
        .CLR_ERR (clr_err),
        .TOS     (tos),
        .DEPTH   (depth),
        .EMPTY   (empty),
        .FULL    (full),
        .OVF     (ovf),
        .UNF     (unf),
        .SEL     (sel)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: four storage slots, an integer depth and two flags.
    int m_e[4];
    int m_depth;
    bit m_ovf;
    bit m_unf;
    int m_sel;
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_e[i] = 0;
            m_depth = 0;
            m_ovf = 0;
            m_unf = 0;
            m_sel = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (clr_err) begin
                m_ovf = 0;
                m_unf = 0;
            end
            m_sel = hold ? 0 : int'(cmd);
            if (!hold) begin
                if (cmd == 2'b01) begin
                    if (m_depth == 4) m_ovf = 1;
                    for (int i = 3; i > 0; i--) m_e[i] = m_e[i-1];
                    m_e[0] = int'(din);
                    m_depth = (m_depth + 1 > 4) ? 4 : m_depth + 1;
                end else if (cmd == 2'b10) begin
                    if (m_depth == 0) m_unf = 1;
                    for (int i = 0; i < 3; i++) m_e[i] = m_e[i+1];
                    m_depth = (m_depth == 0) ? 0 : m_depth - 1;
                end else if (cmd == 2'b11) begin
                    m_e[0] = int'(din);
                    if (m_depth == 0) m_depth = 1;
                end
            end
        end
    end

    // scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_tos",   int'(tos),   m_e[0]);
            chk("model_depth", int'(depth), m_depth);
            chk("model_empty", int'(empty), int'(m_depth == 0));
            chk("model_full",  int'(full),  int'(m_depth == 4));
            chk("model_ovf",   int'(ovf),   int'(m_ovf));
            chk("model_unf",   int'(unf),   int'(m_unf));
            chk("model_sel",   int'(sel),   m_sel);
        end
    end

    // driver: present inputs, take one edge, settle
    task automatic apply(input bit r, input bit h, input logic [1:0] c,
                         input logic [13:0] d, input bit ce);
        rst = r;
        hold = h;
        cmd = c;
        din = d;
        clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [13:0] d);
        apply(0, 0, 2'b01, d, 0);
    endtask

    task automatic pop();
        apply(0, 0, 2'b10, 14'h0, 0);
    endtask

    task automatic nop_clr();
        apply(0, 0, 2'b00, 14'h0, 1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_tos"},   int'(tos),   0);
        chk({tag, "_depth"}, int'(depth), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"},  int'(full),  0);
        chk({tag, "_ovf"},   int'(ovf),   0);
        chk({tag, "_unf"},   int'(unf),   0);
        chk({tag, "_sel"},   int'(sel),   0);
    endtask

    logic [13:0] exp_q[$];

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        cmd = 2'b00;
        din = 14'h0;
        clr_err = 1'b0;
        apply(1, 0, 2'b00, 14'h0, 0);
        apply(1, 1, 2'b01, 14'h1234, 1);
        check_reset_state("reset");

        // fill to full, then drain one past the bottom
        push(14'h0101);
        push(14'h0202);
        push(14'h0303);
        push(14'h0404);
        chk("fill_tos",   int'(tos),   'h0404);
        chk("fill_depth", int'(depth), 4);
        chk("fill_full",  int'(full),  1);
        chk("fill_ovf",   int'(ovf),   0);
        exp_q = '{14'h0303, 14'h0202, 14'h0101, 14'h0101};
        foreach (exp_q[i]) begin
            pop();
            chk("drain_tos", int'(tos), int'(exp_q[i]));
        end
        chk("drain_depth", int'(depth), 0);
        chk("drain_unf",   int'(unf),   0);

        // overflow pushes the bottom out
        push(14'h0101);
        push(14'h0202);
        push(14'h0303);
        push(14'h0404);
        push(14'h0505);
        chk("ovf_tos",   int'(tos),   'h0505);
        chk("ovf_depth", int'(depth), 4);
        chk("ovf_flag",  int'(ovf),   1);
        chk("ovf_sel",   int'(sel),   1);
        exp_q = '{14'h0404, 14'h0303, 14'h0202, 14'h0202};
        foreach (exp_q[i]) begin
            pop();
            chk("ovf_drain_tos", int'(tos), int'(exp_q[i]));
        end
        chk("ovf_sticky", int'(ovf), 1);
        nop_clr();
        chk("ovf_cleared", int'(ovf), 0);

        // underflow, clear, and set-wins-over-clear
        pop();
        chk("unf_depth", int'(depth), 0);
        chk("unf_flag",  int'(unf),   1);
        chk("unf_empty", int'(empty), 1);
        chk("unf_sel",   int'(sel),   2);
        nop_clr();
        chk("unf_cleared", int'(unf), 0);
        chk("nop_sel",     int'(sel), 0);
        apply(0, 0, 2'b10, 14'h0, 1);
        chk("unf_set_wins", int'(unf), 1);

        // HOLD freezes commands; clear still acts during HOLD
        push(14'h0A0A);
        push(14'h0B0B);
        apply(0, 1, 2'b01, 14'h0C0C, 1);
        chk("hold_clr_unf", int'(unf), 0);
        for (int i = 0; i < 2; i++) apply(0, 1, 2'b01, 14'h0C0C, 0);
        chk("hold_tos",   int'(tos),   'h0B0B);
        chk("hold_depth", int'(depth), 2);
        chk("hold_sel",   int'(sel),   0);
        push(14'h0C0C);
        chk("unhold_depth", int'(depth), 3);
        chk("unhold_sel",   int'(sel),   1);
        apply(0, 0, 2'b11, 14'h1111, 0);
        chk("ldtos_mid_tos",   int'(tos),   'h1111);
        chk("ldtos_mid_depth", int'(depth), 3);
        pop();
        chk("ldtos_mid_pop", int'(tos), 'h0B0B);

        // LDTOS on empty, then reset in the middle of a push
        apply(1, 0, 2'b00, 14'h0, 0);
        apply(0, 0, 2'b11, 14'h3FFF, 0);
        chk("ldtos_tos",   int'(tos),   'h3FFF);
        chk("ldtos_depth", int'(depth), 1);
        chk("ldtos_sel",   int'(sel),   3);
        apply(1, 0, 2'b01, 14'h2222, 0);
        check_reset_state("midrst");
        push(14'h0123);
        chk("post_rst_tos",   int'(tos),   'h0123);
        chk("post_rst_depth", int'(depth), 1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cga_mic_stack_ctrl.md
CGA_MIC_STACK_CTRL -- requirements
Module: cga_mic_stack_ctrl

Interface
REQ-001 SHALL have ports CLK (in, 1): sole clock; all state updates on its rising edge.
REQ-002 SHALL have port RST (in, 1): reset, synchronous, active-high.
REQ-003 SHALL have ports HOLD (in, 1): freeze; when 1, CMD is ignored and all state is kept.
REQ-004 SHALL have port CMD (in, 2): stack op; 00 NOP, 01 PUSH, 10 POP, 11 LDTOS (replace top).
REQ-005 SHALL have port DIN (in, 14): return microaddress for PUSH/LDTOS (uPC+1 from sequencer).
REQ-006 SHALL have port CLR_ERR (in, 1): clears sticky error flags.
REQ-007 SHALL have port TOS (out, 14): top-of-stack entry, registered.
REQ-008 SHALL have port DEPTH (out, 3): valid entry count, 0..4.
REQ-009 SHALL have ports EMPTY, FULL (out, 1 each): DEPTH==0, DEPTH==4; combinational from DEPTH.
REQ-010 SHALL have ports OVF, UNF (out, 1 each): sticky overflow/underflow flags.
REQ-011 SHALL have port SEL (out, 2): registered shift-select for downstream bit slices; 00 hold, 01 shift-down (push), 10 shift-up (pop), 11 load-top; equals the CMD applied on the last edge, or 00 if HOLD/RST was active.

Function
REQ-012 SHALL store 4 entries E0 (top)..E3 (bottom), 14 bits each; TOS = E0.
REQ-013 SHALL apply commands with 1-cycle latency: TOS/DEPTH/flags reflect CMD sampled at edge N from edge N onward.
REQ-014 PUSH SHALL set E0<=DIN, E1<=E0, E2<=E1, E3<=E2; DEPTH<=min(DEPTH+1,4).
REQ-015 PUSH with FULL SHALL still shift (old E3 lost), keep DEPTH=4, set OVF.
REQ-016 POP SHALL set E0<=E1, E1<=E2, E2<=E3, E3<=E3 (bottom duplicated); DEPTH<=DEPTH-1.
REQ-017 POP with EMPTY SHALL still shift as REQ-016, keep DEPTH=0, set UNF.
REQ-018 LDTOS SHALL set E0<=DIN only; E1..E3, DEPTH unchanged, except DEPTH 0 becomes 1.
REQ-019 NOP SHALL leave all entries and DEPTH unchanged.
REQ-020 OVF/UNF SHALL stay set until RST or CLR_ERR; CLR_ERR coinciding with a new error event SHALL leave the flag set (set wins).
REQ-021 HOLD=1 SHALL block CMD, but CLR_ERR SHALL still act during HOLD.
REQ-022 DEPTH arithmetic SHALL saturate at 0 and 4; no wrap-around.
REQ-023 Entries SHALL be plain registers with no X propagation; unused CMD encodings do not exist (2-bit fully decoded).

Reset
REQ-024 RST=1 at a rising edge SHALL set E0..E3=0, TOS=0, DEPTH=0, EMPTY=1, FULL=0, OVF=0, UNF=0, SEL=00.
REQ-025 RST SHALL take priority over HOLD, CMD and CLR_ERR, including mid-sequence; first command accepted is the one at the first edge with RST=0.

Verification
REQ-026 Reset then PUSH 0x0101,0x0202,0x0303,0x0404 -> TOS=0x0404, DEPTH=4, FULL=1, OVF=0; four POPs return 0x0303,0x0202,0x0101,0x0101 as TOS, DEPTH 0, UNF=0.
REQ-027 From full (0x0404..0x0101), PUSH 0x0505 -> TOS=0x0505, DEPTH=4, OVF=1, E3=0x0202; four POPs expose 0x0404,0x0303,0x0202,0x0202.
REQ-028 Empty stack, POP -> DEPTH=0, UNF=1, EMPTY=1; CLR_ERR 1 cycle -> UNF=0; POP with CLR_ERR same cycle -> UNF=1.
REQ-029 DEPTH=2, HOLD=1 with CMD=PUSH for 3 cycles -> TOS, DEPTH unchanged, SEL=00; HOLD=0 PUSH -> DEPTH=3, SEL=01.
REQ-030 DEPTH=0, LDTOS 0x3FFF -> TOS=0x3FFF, DEPTH=1, SEL=11; then RST mid-sequence with CMD=PUSH -> all outputs per REQ-024.
